de_issue_stage: RTL and testbench
=================================

# de_issue_stage

Decode/issue stage sitting directly downstream of the fetch stage. It consumes the fetch latch bundle: instruction, PC, PC+4, instruction count, and an invalid flag. It decodes RV32I fields, reads the 32x32 register file, and tracks in-flight destination registers with a per-register scoreboard. It raises a stall to fetch on RAW hazards and drives the DE pipeline latch into AGEX.

## Interface
- DBITS, 32, data/PC width
- INSTBITS, 32, instruction width
- REGNO, 32, architectural registers (x0 hardwired zero)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- fe_inst  in  INSTBITS  instruction from fetch latch
- fe_pc  in  DBITS  PC of fe_inst
- fe_pcplus  in  DBITS  fe_pc+4
- fe_inst_count  in  DBITS  debug counter, passed through unmodified
- fe_invalid  in  1  fetch latch holds no valid instruction
- br_cond_agex  in  1  AGEX redirect this cycle; flush DE
- wb_we  in  1  writeback enable
- wb_rd  in  5  writeback destination
- wb_data  in  DBITS  writeback value
- stall_de  out  1  to fetch: hold PC and fetch latch
- de_valid  out  1  DE latch holds a real instruction
- de_inst, de_pc, de_pcplus, de_inst_count  out  INSTBITS/DBITS  registered pass-through
- de_rs1_val, de_rs2_val  out  DBITS  register operands
- de_imm  out  DBITS  sign-extended immediate (I/S/B/U/J by opcode; 0 for R)
- de_rd  out  5  destination (0 if none)
- de_we  out  1  instruction writes rd (rd!=0 and opcode in OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR)

## Operation
- Decode is combinational from fe_inst. The register file and scoreboard read combinationally. All de_* outputs are registered.
- Uses: rs1 is used by OP, OP-IMM, LOAD, STORE, BRANCH, JALR. rs2 is used by OP, STORE, BRANCH. x0 is never a hazard.
- Regfile: write on posedge when wb_we and wb_rd!=0. A read of a register being written in the same cycle returns wb_data (write-before-read bypass).
- Scoreboard: 2-bit counter per register, busy when nonzero.
  - Increment on issue of an instruction with de_we.
  - Decrement on wb_we for wb_rd!=0.
  - Increment and decrement of the same register in one cycle leave the counter unchanged.
  - Maximum legal count is 3 (AGEX, MEM, WB in flight). Overflow or underflow is an error; the bench asserts it never happens.
- Hazard: hazard = !fe_invalid & (rs1_used & busy(rs1) | rs2_used & busy(rs2)). A register whose only pending writer retires this cycle (count==1 and wb_we to it) is NOT busy.
- stall_de = hazard & !br_cond_agex. The signal is combinational.
- Issue: issue = !fe_invalid & !hazard & !br_cond_agex. Only issue increments the scoreboard.
- DE latch update each cycle, in priority order:
  - reset: zero everything.
  - br_cond_agex: bubble (de_valid=0, de_we=0, other fields zero).
  - hazard: bubble.
  - otherwise: capture decoded fields, with de_valid = !fe_invalid.
- A bubble never increments the scoreboard. A flushed instruction never increments it.

## Timing
- Reset (async assert): de_valid=0, de_we=0, all de_* fields = 0, all scoreboard counters 0, all regfile entries 0. stall_de is 0 after reset since no register is busy.
- Latency: one cycle from the fetch latch to the DE latch.
- A stalled instruction re-evaluates every cycle. It issues in the cycle its last pending writer writes back: the bypassed value is captured in that same posedge.
- br_cond_agex overrides stall in the same cycle. The fetch stage then loads the redirect PC, and the next fe_* arrives with fe_invalid=1.
- Reset mid-stall: all counters clear immediately; no stale busy bits remain.

## Test plan
- Reset: assert reset asynchronously mid-cycle -> de_valid=0, stall_de=0, all counters 0 without waiting for a clock edge.
- Independent stream `addi x1,x0,5; addi x2,x0,7` -> de_valid=1 each cycle, de_imm=5 then 7, de_rd=1 then 2, stall_de=0 throughout.
- RAW hazard: issue `addi x1,x0,5`, next `add x3,x1,x1` -> stall_de=1 with DE bubbles until wb_we/wb_rd=1/wb_data=5. In that cycle the add issues with de_rs1_val=de_rs2_val=5, and x1's counter returns to 0.
- Same-cycle set/clear: issue a writer of x4 while WB retires an older x4 writer -> x4 counter unchanged (1), and a following reader of x4 stalls.
- Flush: br_cond_agex=1 while a hazard is pending -> stall_de=0, next DE latch is a bubble, no counter increments.
- x0 and immediates: `sw x0,8(x0)` and `lui x0,0x12345` -> never stall; lui has de_we=0. B-type with offset -4 gives de_imm=0xFFFFFFFC.

Source files
------------

// File: rtl/de_issue_stage.sv
`default_nettype none
// ============================================================================
// de_issue_stage : RV32I decode/issue with register file, per-register
//                  in-flight scoreboard and RAW stall generation.
// Revision       : 1.0
// ============================================================================
module de_issue_stage #(
  parameter int DBITS    = 32,
  parameter int INSTBITS = 32,
  parameter int REGNO    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INSTBITS-1:0] fe_inst,
  input  logic [DBITS-1:0]    fe_pc,
  input  logic [DBITS-1:0]    fe_pcplus,
  input  logic [DBITS-1:0]    fe_inst_count,
  input  logic                fe_invalid,
  input  logic                br_cond_agex,
  input  logic                wb_we,
  input  logic [4:0]          wb_rd,
  input  logic [DBITS-1:0]    wb_data,
  output logic                stall_de,
  output logic                de_valid,
  output logic [INSTBITS-1:0] de_inst,
  output logic [DBITS-1:0]    de_pc,
  output logic [DBITS-1:0]    de_pcplus,
  output logic [DBITS-1:0]    de_inst_count,
  output logic [DBITS-1:0]    de_rs1_val,
  output logic [DBITS-1:0]    de_rs2_val,
  output logic [DBITS-1:0]    de_imm,
  output logic [4:0]          de_rd,
  output logic                de_we
);

  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;

  logic [6:0]       w_opc;
  logic [4:0]       w_rd, w_rs1, w_rs2;
  logic             w_rs1_used, w_rs2_used, w_writes;
  logic [31:0]      w_imm;
  logic             w_wb_hit, w_rs1_busy, w_rs2_busy;
  logic             w_hazard, w_issue, w_capture;
  logic [REGNO-1:0] w_inc_vec, w_dec_vec;
  logic [DBITS-1:0] w_rs1_val, w_rs2_val;

  logic [DBITS-1:0] r_rf [REGNO];
  logic [1:0]       r_sb [REGNO];

  assign w_opc = fe_inst[6:0];
  assign w_rd  = fe_inst[11:7];
  assign w_rs1 = fe_inst[19:15];
  assign w_rs2 = fe_inst[24:20];

  assign w_rs1_used = (w_opc == c_OPC_OP) || (w_opc == c_OPC_OPIMM) || (w_opc == c_OPC_LOAD) ||
                      (w_opc == c_OPC_STORE) || (w_opc == c_OPC_BRANCH) || (w_opc == c_OPC_JALR);
  assign w_rs2_used = (w_opc == c_OPC_OP) || (w_opc == c_OPC_STORE) || (w_opc == c_OPC_BRANCH);
  assign w_writes   = (w_rd != 5'd0) &&
                      ((w_opc == c_OPC_OP) || (w_opc == c_OPC_OPIMM) || (w_opc == c_OPC_LOAD) ||
                       (w_opc == c_OPC_LUI) || (w_opc == c_OPC_AUIPC) || (w_opc == c_OPC_JAL) ||
                       (w_opc == c_OPC_JALR));

  always_comb begin
    w_imm = '0;
    case (w_opc)
      c_OPC_OPIMM, c_OPC_LOAD, c_OPC_JALR:
        w_imm = {{20{fe_inst[31]}}, fe_inst[31:20]};
      c_OPC_STORE:
        w_imm = {{20{fe_inst[31]}}, fe_inst[31:25], fe_inst[11:7]};
      c_OPC_BRANCH:
        w_imm = {{19{fe_inst[31]}}, fe_inst[31], fe_inst[7], fe_inst[30:25], fe_inst[11:8], 1'b0};
      c_OPC_LUI, c_OPC_AUIPC:
        w_imm = {fe_inst[31:12], 12'b0};
      c_OPC_JAL:
        w_imm = {{11{fe_inst[31]}}, fe_inst[31], fe_inst[19:12], fe_inst[20], fe_inst[30:21], 1'b0};
      default:
        w_imm = '0;
    endcase
  end

  // Writeback is forwarded so an operand retiring this cycle is read fresh.
  assign w_wb_hit  = wb_we && (wb_rd != 5'd0);
  assign w_rs1_val = (w_wb_hit && (wb_rd == w_rs1)) ? wb_data : r_rf[w_rs1];
  assign w_rs2_val = (w_wb_hit && (wb_rd == w_rs2)) ? wb_data : r_rf[w_rs2];

  // A register whose sole pending writer retires now is already free.
  assign w_rs1_busy = (w_rs1 != 5'd0) && (r_sb[w_rs1] != 2'd0) &&
                      !((r_sb[w_rs1] == 2'd1) && w_dec_vec[w_rs1]);
  assign w_rs2_busy = (w_rs2 != 5'd0) && (r_sb[w_rs2] != 2'd0) &&
                      !((r_sb[w_rs2] == 2'd1) && w_dec_vec[w_rs2]);

  assign w_hazard  = !fe_invalid && ((w_rs1_used && w_rs1_busy) || (w_rs2_used && w_rs2_busy));
  assign w_issue   = !fe_invalid && !w_hazard && !br_cond_agex;
  assign w_capture = !w_hazard && !br_cond_agex;
  assign stall_de  = w_hazard && !br_cond_agex;

  assign w_inc_vec = (w_issue && w_writes) ? (REGNO'(1) << w_rd) : '0;
  assign w_dec_vec = w_wb_hit ? (REGNO'(1) << wb_rd) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REGNO; i++) r_rf[i] <= '0;
    end else if (w_wb_hit) begin
      r_rf[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REGNO; i++) r_sb[i] <= 2'd0;
    end else begin
      for (int i = 0; i < REGNO; i++) begin
        if (w_inc_vec[i] && !w_dec_vec[i])
          r_sb[i] <= r_sb[i] + 2'd1;
        else if (w_dec_vec[i] && !w_inc_vec[i])
          r_sb[i] <= r_sb[i] - 2'd1;
      end
    end
  end

  // Flush and hazard both turn the latch into an all-zero bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_valid      <= 1'b0;
      de_we         <= 1'b0;
      de_inst       <= '0;
      de_pc         <= '0;
      de_pcplus     <= '0;
      de_inst_count <= '0;
      de_rs1_val    <= '0;
      de_rs2_val    <= '0;
      de_imm        <= '0;
      de_rd         <= '0;
    end else begin
      de_valid      <= w_capture && !fe_invalid;
      de_we         <= w_capture && !fe_invalid && w_writes;
      de_inst       <= w_capture ? fe_inst : '0;
      de_pc         <= w_capture ? fe_pc : '0;
      de_pcplus     <= w_capture ? fe_pcplus : '0;
      de_inst_count <= w_capture ? fe_inst_count : '0;
      de_rs1_val    <= w_capture ? w_rs1_val : '0;
      de_rs2_val    <= w_capture ? w_rs2_val : '0;
      de_imm        <= w_capture ? w_imm : '0;
      de_rd         <= (w_capture && w_writes) ? w_rd : 5'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_de_issue_stage.sv
`default_nettype none
// tb_de_issue_stage: scoreboard bench; a 3-slot in-flight pipeline model
// drives writebacks and predicts stalls, operands and DE latch contents.
module tb_de_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fe_inst, fe_pc, fe_pcplus, fe_inst_count, wb_data;
  logic        fe_invalid, br_cond_agex, wb_we;
  logic [4:0]  wb_rd;
  logic        stall_de, de_valid, de_we;
  logic [31:0] de_inst, de_pc, de_pcplus, de_inst_count, de_rs1_val, de_rs2_val, de_imm;
  logic [4:0]  de_rd;

  always #5 clk = ~clk;

  de_issue_stage dut (
    .clk(clk), .reset(reset),
    .fe_inst(fe_inst), .fe_pc(fe_pc), .fe_pcplus(fe_pcplus), .fe_inst_count(fe_inst_count),
    .fe_invalid(fe_invalid), .br_cond_agex(br_cond_agex),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall_de(stall_de), .de_valid(de_valid), .de_inst(de_inst), .de_pc(de_pc),
    .de_pcplus(de_pcplus), .de_inst_count(de_inst_count), .de_rs1_val(de_rs1_val),
    .de_rs2_val(de_rs2_val), .de_imm(de_imm), .de_rd(de_rd), .de_we(de_we)
  );

  localparam logic [6:0] OP = 7'h33, OPIMM = 7'h13, LOAD = 7'h03, STORE = 7'h23, BRANCH = 7'h63,
                         JALR = 7'h67, JAL = 7'h6F, LUI = 7'h37, AUIPC = 7'h17;

  int checks = 0;
  int errors = 0;

  // kind: 0 = bubble, 1 = invalid fetch captured, 2 = issued instruction
  typedef struct {
    int          kind;
    logic [31:0] inst, pc, pcp, cnt, rs1, rs2, imm;
    logic [4:0]  rd;
    logic        we, u1, u2;
  } exp_t;
  exp_t q[$];

  // Reference state: architectural registers and the three in-flight slots.
  logic [31:0] m_rf [32];
  logic        pv [3];
  logic [4:0]  prd [3];
  logic [31:0] pd [3];
  logic [31:0] pc, cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] imm_of(input logic [31:0] ins);
    int v;
    v = 0;
    case (ins[6:0])
      OPIMM, LOAD, JALR: v = int'(ins[31:20]) - (ins[31] ? 4096 : 0);
      STORE:  v = int'({ins[31:25], ins[11:7]}) - (ins[31] ? 4096 : 0);
      BRANCH: v = int'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}) - (ins[31] ? 8192 : 0);
      LUI, AUIPC: v = int'(ins[31:12]) * 4096;
      JAL:    v = int'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}) - (ins[31] ? 2097152 : 0);
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic busy(input logic [4:0] r);
    return (r != 5'd0) && ((pv[0] && prd[0] == r) || (pv[1] && prd[1] == r));
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, OP};
  endfunction
  function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] off);
    return {off[11:5], rs2, rs1, 3'b010, off[4:0], STORE};
  endfunction
  function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] off);
    return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], BRANCH};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 8))
      0: x[6:0] = OP;     1: x[6:0] = OPIMM; 2: x[6:0] = LOAD;
      3: x[6:0] = STORE;  4: x[6:0] = BRANCH; 5: x[6:0] = JALR;
      6: x[6:0] = JAL;    7: x[6:0] = LUI;   default: x[6:0] = AUIPC;
    endcase
    x[11:7]  = 5'($urandom_range(0, 7));
    x[19:15] = 5'($urandom_range(0, 7));
    x[24:20] = 5'($urandom_range(0, 7));
    return x;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; prd[i] = '0; pd[i] = '0; end
    q.delete();
  endtask

  // One fetch-latch cycle, entered and left at a falling edge.
  task automatic drive(input logic [31:0] ins, input logic inv, input logic br,
                       input logic [31:0] wval, output logic stalled);
    logic [6:0] op;
    logic [4:0] rd, r1, r2;
    logic       u1, u2, wr, hz, wbv;
    exp_t       e;
    int         n;
    op = ins[6:0]; rd = ins[11:7]; r1 = ins[19:15]; r2 = ins[24:20];
    u1 = op inside {OP, OPIMM, LOAD, STORE, BRANCH, JALR};
    u2 = op inside {OP, STORE, BRANCH};
    wr = (rd != 5'd0) && (op inside {OP, OPIMM, LOAD, LUI, AUIPC, JAL, JALR});
    wbv = pv[2];
    fe_inst = ins; fe_pc = pc; fe_pcplus = pc + 32'd4; fe_inst_count = cnt;
    fe_invalid = inv; br_cond_agex = br;
    wb_we = wbv; wb_rd = prd[2]; wb_data = pd[2];
    hz = !inv && ((u1 && busy(r1)) || (u2 && busy(r2)));
    #1;
    chk("stall_de", stall_de, hz && !br);
    e.kind = (br || hz) ? 0 : (inv ? 1 : 2);
    e.inst = ins; e.pc = pc; e.pcp = pc + 32'd4; e.cnt = cnt;
    e.rs1 = (wbv && prd[2] == r1) ? pd[2] : m_rf[r1];
    e.rs2 = (wbv && prd[2] == r2) ? pd[2] : m_rf[r2];
    e.imm = imm_of(ins); e.rd = wr ? rd : 5'd0; e.we = wr; e.u1 = u1; e.u2 = u2;
    q.push_back(e);
    @(posedge clk);
    if (wbv && prd[2] != 5'd0) m_rf[prd[2]] = pd[2];
    pv[2] = pv[1]; prd[2] = prd[1]; pd[2] = pd[1];
    pv[1] = pv[0]; prd[1] = prd[0]; pd[1] = pd[0];
    pv[0] = !br && !hz && !inv && wr; prd[0] = rd; pd[0] = wval;
    stalled = hz && !br;
    if (!stalled) begin pc = pc + 32'd4; cnt = cnt + 32'd1; end
    @(negedge clk);
    for (int r = 1; r < 8; r++) begin
      n = 0;
      for (int s = 0; s < 3; s++) if (pv[s] && prd[s] == 5'(r)) n++;
      chk($sformatf("sb_count_x%0d", r), 32'(dut.r_sb[r]), n);
    end
  endtask

  task automatic issue_until(input logic [31:0] ins, input logic [31:0] wval);
    logic st;
    int   n;
    n = 0;
    do begin
      drive(ins, 1'b0, 1'b0, wval, st);
      n++;
    end while (st && n < 10);
    chk("stall_bound", st, 1'b0);
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && q.size() > 0) begin
        e = q.pop_front();
        chk("de_valid", de_valid, e.kind == 2);
        chk("de_we", de_we, (e.kind == 2) ? e.we : 1'b0);
        if (e.kind == 0) begin
          chk("bubble_inst", de_inst, 32'd0);
          chk("bubble_rd", 32'(de_rd), 32'd0);
        end
        if (e.kind == 2) begin
          chk("de_inst", de_inst, e.inst);
          chk("de_pc", de_pc, e.pc);
          chk("de_pcplus", de_pcplus, e.pcp);
          chk("de_inst_count", de_inst_count, e.cnt);
          chk("de_imm", de_imm, e.imm);
          chk("de_rd", 32'(de_rd), 32'(e.rd));
          if (e.u1) chk("de_rs1_val", de_rs1_val, e.rs1);
          if (e.u2) chk("de_rs2_val", de_rs2_val, e.rs2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic st, hold, inv, br, prev_br;
    logic [31:0] ins;
    reset = 1'b1;
    fe_inst = '0; fe_pc = '0; fe_pcplus = '0; fe_inst_count = '0;
    fe_invalid = 1'b1; br_cond_agex = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    pc = 32'h1000; cnt = 0;
    clear_model();
    #12;
    chk("reset_de_valid", de_valid, 1'b0);
    chk("reset_de_we", de_we, 1'b0);
    chk("reset_de_inst", de_inst, 32'd0);
    chk("reset_stall", stall_de, 1'b0);
    for (int r = 0; r < 32; r++) chk("reset_sb", 32'(dut.r_sb[r]), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset in the middle of a RAW stall.
    drive(enc_i(OPIMM, 5'd1, 5'd0, 12'd9), 1'b0, 1'b0, 32'd9, st);
    drive(enc_r(5'd3, 5'd1, 5'd1), 1'b0, 1'b0, 32'd1, st);
    @(posedge clk);
    #2;
    chk("pre_reset_stall", stall_de, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_reset_de_valid", de_valid, 1'b0);
    chk("async_reset_stall", stall_de, 1'b0);
    chk("async_reset_sb_x1", 32'(dut.r_sb[1]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    clear_model();

    // Independent stream, then RAW on x1 resolved by a bypassed writeback.
    drive(enc_i(OPIMM, 5'd1, 5'd0, 12'd5), 1'b0, 1'b0, 32'd5, st);
    drive(enc_i(OPIMM, 5'd2, 5'd0, 12'd7), 1'b0, 1'b0, 32'd7, st);
    issue_until(enc_r(5'd3, 5'd1, 5'd1), 32'd10);

    // New x4 writer issues in the cycle an older x4 writer retires.
    drive(enc_i(OPIMM, 5'd4, 5'd0, 12'd11), 1'b0, 1'b0, 32'd11, st);
    drive(enc_i(OPIMM, 5'd0, 5'd0, 12'd0), 1'b0, 1'b0, 32'd0, st);
    drive(enc_i(OPIMM, 5'd0, 5'd0, 12'd0), 1'b0, 1'b0, 32'd0, st);
    drive(enc_i(OPIMM, 5'd4, 5'd0, 12'd22), 1'b0, 1'b0, 32'd22, st);
    issue_until(enc_r(5'd5, 5'd4, 5'd0), 32'd33);

    // Redirect while a hazard is pending, then an invalid fetch.
    drive(enc_i(OPIMM, 5'd6, 5'd0, 12'd3), 1'b0, 1'b0, 32'd3, st);
    drive(enc_r(5'd7, 5'd6, 5'd6), 1'b0, 1'b1, 32'd44, st);
    drive(enc_r(5'd7, 5'd6, 5'd6), 1'b1, 1'b0, 32'd44, st);

    // x0 operands/destinations and a negative branch offset.
    drive(enc_s(5'd0, 5'd0, 12'd8), 1'b0, 1'b0, 32'd0, st);
    drive({20'h12345, 5'd0, LUI}, 1'b0, 1'b0, 32'd0, st);
    drive(enc_b(5'd0, 5'd0, 13'h1FFC), 1'b0, 1'b0, 32'd0, st);

    // Randomized traffic.
    hold = 1'b0; prev_br = 1'b0; ins = '0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        ins = rand_inst();
        inv = ($urandom_range(0, 7) == 0);
      end else begin
        inv = 1'b0;
      end
      if (prev_br) inv = 1'b1;
      br = ($urandom_range(0, 15) == 0);
      drive(ins, inv, br, $urandom, st);
      hold = st;
      prev_br = br;
      if (br) pc = $urandom & 32'hFFFF_FFFC;
    end

    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
